ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Return address stack with multi-level speculation checkpoints; next generation of the single-branch RAS in the fetch/branch-prediction unit.
- Supports up to NCKPT outstanding unresolved branches.
- Each checkpoint allows exact recovery of the TOS pointer, occupancy and top entry on misprediction.
- Storage is a circular flop array, so overflow silently discards the oldest return address.

Parameters:
- WIDTH, 32, return address width.
- DEPTH, 16, stack entries; power of two, ≥2.
- NCKPT, 4, maximum outstanding checkpoints; power of two, ≥2.
- CKPT_W, $clog2(NCKPT), checkpoint id width (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- push  in  1  call: push din.
- pop  in  1  return: pop top.
- din  in  WIDTH  return address to push.
- dout  out  WIDTH  current top of stack, registered view.
- empty  out  1  occupancy == 0.
- branch  in  1  allocate checkpoint of post-operation state this cycle.
- ckpt_ready  out  1  a free checkpoint slot exists.
- ckpt_id  out  CKPT_W  id that a branch this cycle receives.
- resolve  in  1  resolve checkpoint resolve_id.
- resolve_id  in  CKPT_W  checkpoint being resolved.
- mispredict  in  1  qualifies resolve: 1 = restore, 0 = correct.
- underflow  out  1  one-cycle pulse when pop is requested while empty.

Behaviour:
- Reset: tos=0, count=0, all entries 0, checkpoint queue empty, dout=0, empty=1, ckpt_ready=1, ckpt_id=0, underflow=0. Reset mid-speculation discards all checkpoints.
- dout always equals entry[tos]. Read latency to reflect a push or pop is 1 cycle.
- push only: tos=tos+1 mod DEPTH; entry[tos+1]=din; count=min(count+1, DEPTH). At count==DEPTH the oldest entry is overwritten.
- pop only:
  - If count>0: tos=tos-1 mod DEPTH, count-1.
  - If count==0: no state change, underflow=1.
- push and pop in the same cycle: entry[tos]=din; tos and count unchanged. Underflow is never asserted in this case.
- Checkpoint record = {tos, count, entry[tos]}, captured after this cycle's push/pop is applied.
- branch with ckpt_ready=1:
  - Record goes to slot ckpt_id.
  - Slot is marked busy; allocation pointer advances.
- branch with ckpt_ready=0: ignored; no state change.
- Checkpoints form an in-order ring with head (oldest) and tail (next allocation). ckpt_ready = busy count < NCKPT.
- resolve with mispredict=0:
  - Marks slot done.
  - Each cycle, head advances past a done slot (retires at most one per cycle).
  - Resolving a non-busy slot is ignored.
- resolve with mispredict=1 on a busy slot k:
  - tos, count and entry[saved tos] are restored from slot k.
  - Slot k and all younger slots are freed (tail=k).
  - Any push, pop or branch in the same cycle is ignored.
  - dout shows the restored value the next cycle.
- Mispredict on a non-busy slot: ignored.
- resolve (correct) and branch in the same cycle: both take effect.

Optional Feature:
- Macro RAS_STATS_EN. When defined, three extra outputs are added:
  - stat_overflow [15:0]: pushes with count==DEPTH.
  - stat_underflow [15:0]: underflow pulses.
  - stat_restore [15:0]: accepted mispredicts.
- All three counters saturate at 16'hFFFF and reset to 0.
- Without the macro: no extra ports, no counter logic.

Decomposition:
- Package ras_pkg holds:
  - typedef ras_ckpt_t {tos, count, top}, parameterised via localparam widths.
  - Width helper functions.
- Sub-module ras_ckpt_queue holds:
  - Ring pointers, busy/done bits and record storage.
  - Allocation, retire and truncate-on-mispredict logic.
- The top level holds the stack array and the push/pop/restore datapath.

Test Plan:
- Push 0x100, 0x200, 0x300, then pop twice -> dout 0x300, then 0x200, then 0x100; empty=0 throughout; then pop twice -> second pop pulses underflow=1, count stays 0.
- DEPTH=16: push 1..17, then pop 16 times -> dout 17 down to 2; the 16th pop leaves empty=1; value 1 is lost.
- Push A, branch (id 0), push B, push C, then mispredict id 0 -> next cycle dout=A, count=1.
- Push A; branch id0; pop; branch id1; push X. Then correct id0, then mispredict id1 -> dout reflects the post-pop state (stack empty); id0 retired; ckpt_ready=1.
- Issue 4 branches without resolves -> ckpt_ready=0; a 5th branch is ignored; resolve id0 correct -> ckpt_ready=1 the next cycle.
- Push and pop of 0xDEAD in the same cycle with top=0xBEEF -> dout=0xDEAD, count unchanged. The same cycle with mispredict on a busy slot -> push/pop ignored and restore applied.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared types and width helpers for the checkpointed return address stack.
// Default-configuration record type plus helpers used to size parameterised copies.
package ras_pkg;

   localparam int RAS_WIDTH = 32;
   localparam int RAS_DEPTH = 16;
   localparam int RAS_NCKPT = 4;

   // Index width for an n-entry array (at least one bit).
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Occupancy width: must hold the value n itself.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

   // Packed size of one checkpoint record {tos, count, top}.
   function automatic int rec_w(input int w, input int d);
      return ptr_w(d) + cnt_w(d) + w;
   endfunction

   localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
   localparam int RAS_CNT_W = $clog2(RAS_DEPTH) + 1;

   typedef struct packed {
      logic [RAS_PTR_W-1:0] tos;
      logic [RAS_CNT_W-1:0] count;
      logic [RAS_WIDTH-1:0] top;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_queue.sv
// In-order ring of speculation checkpoints: allocate at tail, retire at head,
// truncate to a mispredicted slot. Ports: alloc/rec_in, ready/id, resolve, restore/rec_out.
module ras_ckpt_queue
   import ras_pkg::*;
#(
   parameter int NCKPT  = 4,
   parameter int CKPT_W = $clog2(NCKPT),
   parameter int REC_W  = 53
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc,
   input  logic [REC_W-1:0]  rec_in,
   output logic              ready,
   output logic [CKPT_W-1:0] id,
   input  logic              resolve,
   input  logic [CKPT_W-1:0] resolve_id,
   input  logic              mispredict,
   output logic              restore,
   output logic [REC_W-1:0]  rec_out
);

   localparam logic [CKPT_W:0] FULL = (CKPT_W+1)'(NCKPT);

   logic [CKPT_W-1:0] head, tail, keep;
   logic [CKPT_W:0]   nbusy, younger;
   logic [NCKPT-1:0]  busy, done, freed;
   logic [REC_W-1:0]  recs [NCKPT];
   logic              ok_res, retire, do_alloc;

   assign ready    = nbusy < FULL;
   assign id       = tail;
   assign rec_out  = recs[resolve_id];
   assign restore  = resolve & mispredict & busy[resolve_id];
   assign ok_res   = resolve & ~mispredict & busy[resolve_id];
   // A slot resolved this cycle at the head retires immediately.
   assign retire   = busy[head] &
                     (done[head] | (ok_res & (resolve_id == head)));
   assign do_alloc = alloc & ready & ~restore;

   // Slots older than the mispredicted one survive; it and younger are freed.
   assign keep    = resolve_id - head;
   assign younger = nbusy - {1'b0, keep};

   always_comb begin
      logic [CKPT_W-1:0] off;
      off   = '0;
      freed = '0;
      for (int i = 0; i < NCKPT; i++) begin
         off      = CKPT_W'(i) - resolve_id;
         freed[i] = {1'b0, off} < younger;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         nbusy <= '0;
         busy  <= '0;
         done  <= '0;
      end else if (restore) begin
         tail  <= resolve_id;
         nbusy <= {1'b0, keep};
         busy  <= busy & ~freed;
         done  <= done & ~freed;
      end else begin
         if (ok_res)
            done[resolve_id] <= 1'b1;
         if (retire) begin
            busy[head] <= 1'b0;
            done[head] <= 1'b0;
            head       <= head + 1'b1;
         end
         if (do_alloc) begin
            busy[tail] <= 1'b1;
            done[tail] <= 1'b0;
            tail       <= tail + 1'b1;
         end
         case ({do_alloc, retire})
            2'b10:   nbusy <= nbusy + 1'b1;
            2'b01:   nbusy <= nbusy - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_alloc)
         recs[tail] <= rec_in;
   end

endmodule

// File: rtl/ras_ckpt.sv
// Return address stack (circular, overflow drops oldest) with checkpointed recovery.
// Ports: push/pop/din -> dout/empty/underflow; branch -> ckpt_ready/ckpt_id;
// resolve/resolve_id/mispredict restore. Optional RAS_STATS_EN adds stat_* counters.
module ras_ckpt
   import ras_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 16,
   parameter int NCKPT  = 4,
   parameter int CKPT_W = $clog2(NCKPT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic              empty,
   input  logic              branch,
   output logic              ckpt_ready,
   output logic [CKPT_W-1:0] ckpt_id,
   input  logic              resolve,
   input  logic [CKPT_W-1:0] resolve_id,
   input  logic              mispredict,
   output logic              underflow
`ifdef RAS_STATS_EN
  ,output logic [15:0]       stat_overflow,
   output logic [15:0]       stat_underflow,
   output logic [15:0]       stat_restore
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam int RW = rec_w(WIDTH, DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [PW-1:0]    tos;
      logic [CW-1:0]    count;
      logic [WIDTH-1:0] top;
   } rec_t;

   logic [WIDTH-1:0] stack [DEPTH];
   logic [PW-1:0]    tos, tos_n, tos_p1, tos_m1, wr_idx;
   logic [CW-1:0]    count, cnt_n;
   logic [WIDTH-1:0] top_n;
   logic             wr, uf, restore, do_push, do_pop;
   rec_t             rec_n, rec_r;

   assign dout    = stack[tos];
   assign empty   = (count == '0);
   assign do_push = push & ~restore;
   assign do_pop  = pop & ~restore;
   assign tos_p1  = tos + 1'b1;
   assign tos_m1  = tos - 1'b1;

   // Post-operation state; also the record captured by a branch.
   always_comb begin
      tos_n  = tos;
      cnt_n  = count;
      top_n  = stack[tos];
      wr     = 1'b0;
      wr_idx = tos;
      uf     = 1'b0;
      unique case (1'b1)
         (do_push & do_pop): begin
            wr    = 1'b1;
            top_n = din;
         end
         (do_push & ~do_pop): begin
            tos_n  = tos_p1;
            wr     = 1'b1;
            wr_idx = tos_p1;
            top_n  = din;
            if (count != FULL)
               cnt_n = count + 1'b1;
         end
         (do_pop & ~do_push): begin
            if (count != '0) begin
               tos_n = tos_m1;
               cnt_n = count - 1'b1;
               top_n = stack[tos_m1];
            end else begin
               uf = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign rec_n = '{tos: tos_n, count: cnt_n, top: top_n};

   ras_ckpt_queue #(
      .NCKPT  (NCKPT),
      .CKPT_W (CKPT_W),
      .REC_W  (RW)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .alloc      (branch),
      .rec_in     (rec_n),
      .ready      (ckpt_ready),
      .id         (ckpt_id),
      .resolve    (resolve),
      .resolve_id (resolve_id),
      .mispredict (mispredict),
      .restore    (restore),
      .rec_out    (rec_r)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         tos       <= '0;
         count     <= '0;
         underflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            stack[i] <= '0;
      end else begin
         underflow <= uf;
         if (restore) begin
            tos              <= rec_r.tos;
            count            <= rec_r.count;
            stack[rec_r.tos] <= rec_r.top;
         end else begin
            tos   <= tos_n;
            count <= cnt_n;
            if (wr)
               stack[wr_idx] <= din;
         end
      end
   end

`ifdef RAS_STATS_EN
   logic ovf_ev;
   assign ovf_ev = do_push & ~do_pop & (count == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_overflow  <= '0;
         stat_underflow <= '0;
         stat_restore   <= '0;
      end else begin
         if (ovf_ev && stat_overflow != 16'hFFFF)
            stat_overflow <= stat_overflow + 1'b1;
         if (uf && stat_underflow != 16'hFFFF)
            stat_underflow <= stat_underflow + 1'b1;
         if (restore && stat_restore != 16'hFFFF)
            stat_restore <= stat_restore + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed self-checking bench for ras_ckpt (default build).
// Inputs change 1 time unit after posedge; outputs sampled at the same point.
module tb_ras_ckpt;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0, pop = 1'b0, branch = 1'b0;
   logic        resolve = 1'b0, mispredict = 1'b0;
   logic [1:0]  resolve_id = '0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        empty, ckpt_ready, underflow;
   logic [1:0]  ckpt_id;

   int checks = 0;
   int errors = 0;

   ras_ckpt #(.WIDTH(32), .DEPTH(16), .NCKPT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .din        (din),
      .dout       (dout),
      .empty      (empty),
      .branch     (branch),
      .ckpt_ready (ckpt_ready),
      .ckpt_id    (ckpt_id),
      .resolve    (resolve),
      .resolve_id (resolve_id),
      .mispredict (mispredict),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push = 0; pop = 0; branch = 0;
      resolve = 0; mispredict = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic do_push(input logic [31:0] d);
      push = 1; din = d; tick(); idle();
   endtask

   task automatic do_pop();
      pop = 1; tick(); idle();
   endtask

   task automatic do_branch();
      branch = 1; tick(); idle();
   endtask

   task automatic do_resolve(input logic [1:0] k, input logic mp);
      resolve = 1; resolve_id = k; mispredict = mp; tick(); idle();
   endtask

   task automatic test_reset();
      do_reset();
      do_push(32'h1234);
      do_branch();
      rst = 1; tick(); rst = 0;
      checks++; if (dout !== 32'h0) begin errors++;
         $display("FAIL rst_dout got=%h exp=%h", dout, 32'h0); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL rst_empty got=%b exp=1", empty); end
      checks++; if (ckpt_ready !== 1'b1) begin errors++;
         $display("FAIL rst_ready got=%b exp=1", ckpt_ready); end
      checks++; if (ckpt_id !== 2'd0) begin errors++;
         $display("FAIL rst_id got=%0d exp=0", ckpt_id); end
      checks++; if (underflow !== 1'b0) begin errors++;
         $display("FAIL rst_uf got=%b exp=0", underflow); end
   endtask

   task automatic test_push_pop();
      do_reset();
      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      checks++; if (dout !== 32'h300 || empty !== 1'b0) begin errors++;
         $display("FAIL pp_top got=%h/%b exp=300/0", dout, empty); end
      do_pop();
      checks++; if (dout !== 32'h200 || empty !== 1'b0) begin errors++;
         $display("FAIL pp_pop1 got=%h/%b exp=200/0", dout, empty); end
      do_pop();
      checks++; if (dout !== 32'h100 || empty !== 1'b0) begin errors++;
         $display("FAIL pp_pop2 got=%h/%b exp=100/0", dout, empty); end
      do_pop();
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++;
         $display("FAIL pp_pop3 empty/uf got=%b/%b exp=1/0", empty, underflow); end
      do_pop();
      checks++; if (underflow !== 1'b1 || empty !== 1'b1) begin errors++;
         $display("FAIL pp_uf uf/empty got=%b/%b exp=1/1", underflow, empty); end
      tick();
      checks++; if (underflow !== 1'b0) begin errors++;
         $display("FAIL pp_uf_pulse got=%b exp=0", underflow); end
      do_push(32'h42);
      checks++; if (dout !== 32'h42 || empty !== 1'b0) begin errors++;
         $display("FAIL pp_after_uf got=%h/%b exp=42/0", dout, empty); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 17; i++) do_push(32'(i));
      checks++; if (dout !== 32'd17) begin errors++;
         $display("FAIL ovf_top got=%0d exp=17", dout); end
      for (int j = 1; j <= 16; j++) begin
         do_pop();
         if (j < 16) begin
            checks++;
            if (dout !== 32'(17 - j) || empty !== 1'b0) begin errors++;
               $display("FAIL ovf_pop%0d got=%0d/%b exp=%0d/0",
                        j, dout, empty, 17 - j); end
         end else begin
            checks++;
            if (empty !== 1'b1 || underflow !== 1'b0) begin errors++;
               $display("FAIL ovf_last empty/uf got=%b/%b exp=1/0",
                        empty, underflow); end
         end
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      do_push(32'hA);
      checks++; if (ckpt_id !== 2'd0) begin errors++;
         $display("FAIL mp_id0 got=%0d exp=0", ckpt_id); end
      do_branch();
      checks++; if (ckpt_id !== 2'd1 || ckpt_ready !== 1'b1) begin errors++;
         $display("FAIL mp_alloc id/rdy got=%0d/%b exp=1/1", ckpt_id, ckpt_ready); end
      do_push(32'hB); do_push(32'hC);
      checks++; if (dout !== 32'hC) begin errors++;
         $display("FAIL mp_pre got=%h exp=c", dout); end
      do_resolve(2'd0, 1'b1);
      checks++; if (dout !== 32'hA || empty !== 1'b0) begin errors++;
         $display("FAIL mp_restore got=%h/%b exp=a/0", dout, empty); end
      checks++; if (ckpt_id !== 2'd0 || ckpt_ready !== 1'b1) begin errors++;
         $display("FAIL mp_free id/rdy got=%0d/%b exp=0/1", ckpt_id, ckpt_ready); end
      do_pop();
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL mp_count got empty=%b exp=1", empty); end
   endtask

   task automatic test_nested();
      do_reset();
      do_push(32'hA);
      do_branch();
      do_pop();
      do_branch();
      do_push(32'h5A5A);
      do_resolve(2'd3, 1'b1);
      checks++; if (dout !== 32'h5A5A || empty !== 1'b0) begin errors++;
         $display("FAIL nest_idle_mp got=%h/%b exp=5a5a/0", dout, empty); end
      do_resolve(2'd0, 1'b0);
      checks++; if (dout !== 32'h5A5A || ckpt_id !== 2'd2) begin errors++;
         $display("FAIL nest_ok got=%h/%0d exp=5a5a/2", dout, ckpt_id); end
      do_resolve(2'd1, 1'b1);
      checks++; if (empty !== 1'b1 || dout !== 32'h0) begin errors++;
         $display("FAIL nest_restore got=%b/%h exp=1/0", empty, dout); end
      checks++; if (ckpt_ready !== 1'b1 || ckpt_id !== 2'd1) begin errors++;
         $display("FAIL nest_q got=%b/%0d exp=1/1", ckpt_ready, ckpt_id); end
      do_branch(); do_branch(); do_branch();
      checks++; if (ckpt_ready !== 1'b1) begin errors++;
         $display("FAIL nest_3br got=%b exp=1", ckpt_ready); end
      do_branch();
      checks++; if (ckpt_ready !== 1'b0) begin errors++;
         $display("FAIL nest_4br got=%b exp=0", ckpt_ready); end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         checks++; if (ckpt_id !== 2'(i) || ckpt_ready !== 1'b1) begin errors++;
            $display("FAIL full_id%0d got=%0d/%b exp=%0d/1",
                     i, ckpt_id, ckpt_ready, i); end
         do_branch();
      end
      checks++; if (ckpt_ready !== 1'b0 || ckpt_id !== 2'd0) begin errors++;
         $display("FAIL full_4 got=%b/%0d exp=0/0", ckpt_ready, ckpt_id); end
      do_branch();
      checks++; if (ckpt_ready !== 1'b0 || ckpt_id !== 2'd0) begin errors++;
         $display("FAIL full_5th got=%b/%0d exp=0/0", ckpt_ready, ckpt_id); end
      do_resolve(2'd0, 1'b0);
      checks++; if (ckpt_ready !== 1'b1 || ckpt_id !== 2'd0) begin errors++;
         $display("FAIL full_retire got=%b/%0d exp=1/0", ckpt_ready, ckpt_id); end
      branch = 1; resolve = 1; resolve_id = 2'd1; mispredict = 0;
      tick(); idle();
      checks++; if (ckpt_ready !== 1'b1 || ckpt_id !== 2'd1) begin errors++;
         $display("FAIL full_br_res got=%b/%0d exp=1/1", ckpt_ready, ckpt_id); end
      branch = 1; tick(); idle();
      checks++; if (ckpt_ready !== 1'b0) begin errors++;
         $display("FAIL full_refill got=%b exp=0", ckpt_ready); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_push(32'hBEEF);
      push = 1; pop = 1; din = 32'hDEAD; tick(); idle();
      checks++; if (dout !== 32'hDEAD || empty !== 1'b0) begin errors++;
         $display("FAIL b2b_swap got=%h/%b exp=dead/0", dout, empty); end
      do_pop();
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL b2b_count got empty=%b exp=1", empty); end
      push = 1; pop = 1; din = 32'h55; tick(); idle();
      checks++; if (underflow !== 1'b0 || empty !== 1'b1 || dout !== 32'h55) begin
         errors++;
         $display("FAIL b2b_empty got uf=%b e=%b d=%h exp=0/1/55",
                  underflow, empty, dout); end
      do_reset();
      do_push(32'hBEEF);
      do_branch();
      do_push(32'h1);
      push = 1; pop = 1; din = 32'hDEAD; branch = 1;
      resolve = 1; resolve_id = 2'd0; mispredict = 1;
      tick(); idle();
      checks++; if (dout !== 32'hBEEF || underflow !== 1'b0) begin errors++;
         $display("FAIL b2b_mp got=%h/%b exp=beef/0", dout, underflow); end
      checks++; if (ckpt_id !== 2'd0 || ckpt_ready !== 1'b1) begin errors++;
         $display("FAIL b2b_mp_q got=%0d/%b exp=0/1", ckpt_id, ckpt_ready); end
      do_pop();
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL b2b_mp_cnt got empty=%b exp=1", empty); end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_mispredict();
      test_nested();
      test_full();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
